// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-client arbiter: opcodes,
// default widths and the client-id type.
package alu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int OPW_DEF   = 3;

    localparam logic [OPW_DEF-1:0] OP_ADD = 3'b000;
    localparam logic [OPW_DEF-1:0] OP_SUB = 3'b001;
    localparam logic [OPW_DEF-1:0] OP_AND = 3'b010;
    localparam logic [OPW_DEF-1:0] OP_OR  = 3'b011;
    localparam logic [OPW_DEF-1:0] OP_XOR = 3'b100;
    localparam logic [OPW_DEF-1:0] OP_NOT = 3'b101;
    localparam logic [OPW_DEF-1:0] OP_SHL = 3'b110;
    localparam logic [OPW_DEF-1:0] OP_SHR = 3'b111;

    typedef logic client_id_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and the arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_carry;
    logic             rsp_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_out, rsp_carry, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_out, rsp_carry, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// The existing combinational 8-bit ALU: result plus carry and zero flags.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [OPW_DEF-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y,
    output logic               carry,
    output logic               zero
);

    logic [WIDTH:0] sum;

    // For SUB the carry flag is the borrow out of the extended subtraction.
    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                sum   = {1'b0, a} - {1'b0, b};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            default: begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two clients, with a one-entry
// result register that is returned to whichever client issued the op.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    if (WIDTH != WIDTH_DEF || OPW != OPW_DEF) begin : g_bad_width
        $error("alu_arbiter: WIDTH/OPW must match the ALU (%0d/%0d)", WIDTH_DEF, OPW_DEF);
    end

    logic             full_p1;
    client_id_t       owner_p1;
    client_id_t       last_grant_p1;
    logic [WIDTH-1:0] out_p1;
    logic             carry_p1;
    logic             zero_p1;

    logic             owner_rdy;
    logic             can_accept;
    logic             grant_any;
    client_id_t       win;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;
    logic             alu_zero;

    function automatic client_id_t pick(input logic v0, input logic v1, input client_id_t last);
        if (v0 && v1) return ~last;
        else if (v1)  return 1'b1;
        else          return 1'b0;
    endfunction

    // Stage p0: arbitration and operand mux into the ALU
    assign owner_rdy  = owner_p1 ? bus.rsp1_ready : bus.rsp0_ready;
    // Reset gates the grant so a request present during reset is never taken.
    assign can_accept = !rst && (!full_p1 || owner_rdy);
    assign win        = pick(bus.req0_valid, bus.req1_valid, last_grant_p1);
    assign grant_any  = can_accept && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = grant_any && (win == 1'b0);
    assign bus.req1_ready = grant_any && (win == 1'b1);

    assign alu_op = win ? bus.req1_op : bus.req0_op;
    assign alu_a  = win ? bus.req1_a  : bus.req0_a;
    assign alu_b  = win ? bus.req1_b  : bus.req0_b;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .op    (alu_op),
        .a     (alu_a),
        .b     (alu_b),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    // Stage p1: result register; a new accept overrides the owner's drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_p1       <= 1'b0;
            owner_p1      <= 1'b0;
            last_grant_p1 <= 1'b1;
            out_p1        <= '0;
            carry_p1      <= 1'b0;
            zero_p1       <= 1'b0;
        end else if (grant_any) begin
            full_p1       <= 1'b1;
            owner_p1      <= win;
            last_grant_p1 <= win;
            out_p1        <= alu_y;
            carry_p1      <= alu_carry;
            zero_p1       <= alu_zero;
        end else if (full_p1 && owner_rdy) begin
            full_p1       <= 1'b0;
        end
    end

    assign bus.rsp0_valid = full_p1 && (owner_p1 == 1'b0);
    assign bus.rsp1_valid = full_p1 && (owner_p1 == 1'b1);
    assign bus.rsp_out    = out_p1;
    assign bus.rsp_carry  = carry_p1;
    assign bus.rsp_zero   = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, arbitration order, backpressure,
// back-to-back issue and non-owner ready, with hand-computed results.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req0_valid = v;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
    endtask

    task automatic set1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req1_valid = v;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        set1(1'b0, OP_ADD, 8'h00, 8'h00);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset values, with a request present during reset
        set0(1'b1, OP_ADD, 8'h01, 8'h01);
        #2;
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rst_rsp_out",    32'(bus.rsp_out),    32'd0);
        check("rst_flags",      32'({bus.rsp_carry, bus.rsp_zero}), 32'd0);
        tick();
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        rst = 1'b0;
        #1;

        // Test 1: result full for client 1, then reset mid-operation
        set1(1'b1, OP_ADD, 8'h01, 8'h02);
        #1;
        check("t1_req1_ready", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(1'b0, OP_ADD, 8'h00, 8'h00);
        check("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("t1_rsp_out",    32'(bus.rsp_out),    32'h03);
        set0(1'b1, OP_AND, 8'hFF, 8'h0F);
        rst = 1'b1;
        #1;
        check("t1_mid_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("t1_mid_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("t1_mid_rsp_out",    32'(bus.rsp_out),    32'd0);
        tick();
        rst = 1'b0;
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        #1;
        set0(1'b1, OP_ADD, 8'h00, 8'h00);
        set1(1'b1, OP_ADD, 8'h00, 8'h00);
        #1;
        check("t1_first_grant0", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        set1(1'b0, OP_ADD, 8'h00, 8'h00);
        #1;

        // Test 2: client 0 ADD 0x80+0x80
        set0(1'b1, OP_ADD, 8'h80, 8'h80);
        #1;
        check("t2_req0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        check("t2_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t2_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("t2_rsp_out",    32'(bus.rsp_out),    32'h00);
        check("t2_zero",       32'(bus.rsp_zero),   32'd1);
        check("t2_carry",      32'(bus.rsp_carry),  32'd1);
        bus.rsp0_ready = 1'b1;
        tick();
        check("t2_drained", 32'(bus.rsp0_valid), 32'd0);
        bus.rsp0_ready = 1'b0;

        // Test 3: both clients contend, responses taken immediately
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set0(1'b1, OP_SUB, 8'h05, 8'h03);
        set1(1'b1, OP_XOR, 8'hF0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t3_grant%0d", i), 32'({bus.req1_ready, bus.req0_ready}),
                  (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            check($sformatf("t3_owner%0d", i), 32'({bus.rsp1_valid, bus.rsp0_valid}),
                  (i % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("t3_out%0d", i), 32'(bus.rsp_out),
                  (i % 2 == 0) ? 32'h02 : 32'h0F);
        end
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        set1(1'b0, OP_ADD, 8'h00, 8'h00);
        tick();
        check("t3_drained", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b00);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Test 4: client 1 holds its result while client 0 waits
        set1(1'b1, OP_SHL, 8'h81, 8'h00);
        #1;
        check("t4_req1_ready", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(1'b0, OP_ADD, 8'h00, 8'h00);
        set0(1'b1, OP_ADD, 8'h03, 8'h04);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_stall_req0_ready%0d", i), 32'(bus.req0_ready), 32'd0);
            check($sformatf("t4_stall_out%0d", i), 32'(bus.rsp_out), 32'h02);
            check($sformatf("t4_stall_v1_%0d", i), 32'(bus.rsp1_valid), 32'd1);
            tick();
        end
        check("t4_carry", 32'(bus.rsp_carry), 32'd1);
        bus.rsp1_ready = 1'b1;
        #1;
        check("t4_release_req0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.rsp1_ready = 1'b0;
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        check("t4_new_owner", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b01);
        check("t4_new_out",   32'(bus.rsp_out), 32'h07);
        bus.rsp0_ready = 1'b1;
        tick();

        // Test 5: back-to-back issue from client 0
        set0(1'b1, OP_NOT, 8'h00, 8'h00);
        tick();
        check("t5_not_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t5_not_out",   32'(bus.rsp_out),    32'hFF);
        set0(1'b1, OP_SHR, 8'hFF, 8'h00);
        tick();
        check("t5_shr_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t5_shr_out",   32'(bus.rsp_out),    32'h7F);
        check("t5_shr_carry", 32'(bus.rsp_carry),  32'd1);
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        tick();
        check("t5_drained", 32'(bus.rsp0_valid), 32'd0);
        bus.rsp0_ready = 1'b0;

        // Test 6: ready from the non-owner is ignored
        set0(1'b1, OP_OR, 8'h12, 8'h21);
        tick();
        set0(1'b0, OP_ADD, 8'h00, 8'h00);
        bus.rsp1_ready = 1'b1;
        tick();
        bus.rsp1_ready = 1'b0;
        check("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("t6_rsp_out",    32'(bus.rsp_out),    32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
